// File: rtl/ivn_pkg.sv
// ivn_pkg: definitions shared by the iterated von Neumann extractor (ivn_top)
// and the word packer (ivn_packer).
//   IVN_LANES    : number of extractor iteration levels (one bit per level).
//   ivn_lvl_t    : 6-bit per-level vector type (bits or valids).
//   ivn_popcount : number of set bits in a level vector (0..6).
package ivn_pkg;

    localparam int IVN_LANES = 6;

    typedef logic [IVN_LANES-1:0] ivn_lvl_t;

    function automatic logic [2:0] ivn_popcount(input ivn_lvl_t v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < IVN_LANES; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ivn_packer_if.sv
// ivn_packer_if: the extractor-side input bundle and the word-side
// ready/valid output bundle of ivn_packer.
//   s_vn, s_vn_valid : extractor bits and per-level valids (no back-pressure).
//   out_data         : head-of-FIFO word, registered.
//   out_valid        : FIFO non-empty, registered.
//   out_ready        : consumer accept.
// Handshake: a word transfers on a rising edge where out_valid & out_ready
// are both 1; out_valid never depends on out_ready, and out_data is stable
// while out_valid is 1 and out_ready is 0.
// Modports: master = environment (extractor + consumer), slave = packer.
interface ivn_packer_if #(
    parameter int WORD_W = 32
);
    import ivn_pkg::*;

    ivn_lvl_t          s_vn;
    ivn_lvl_t          s_vn_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output s_vn, s_vn_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  s_vn, s_vn_valid, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/ivn_packer_fifo.sv
// ivn_packer_fifo: synchronous FIFO with a registered head word.
//   clk, reset  : clock, synchronous active-high reset.
//   wr_en/wr_data : push request; accepted when not full or when a pop
//                   happens in the same cycle.
//   rd_en       : pop request; effective when not empty.
//   rd_data     : registered head word; holds its last value when empty.
//   rd_valid    : registered non-empty flag.
//   full, empty : occupancy flags.
module ivn_packer_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d;
    logic          push, pop;
    logic [AW-1:0] rd_ptr_nx;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign rd_data  = head_q;
    assign rd_valid = valid_q;

    always_comb begin
        pop       = rd_en & ~empty;
        // A pop frees a slot this cycle, so a push into a full FIFO is fine.
        push      = wr_en & (~full | pop);
        rd_ptr_nx = rd_ptr_q + AW'(1);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_nx;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // The head register tracks mem[rd_ptr]. When the FIFO is (or becomes)
        // a single-entry pass-through, the new word goes straight to the head.
        if (pop) begin
            if (count_q == CW'(1)) begin
                if (push) begin
                    head_d = wr_data;
                end
            end else begin
                head_d = mem_q[rd_ptr_nx];
            end
        end else if (empty && push) begin
            head_d = wr_data;
        end

        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ivn_packer.sv
// ivn_packer: packs the compacted von Neumann extractor bits into WORD_W-bit
// words (LSB-first) and queues them in a small FIFO drained by ready/valid.
//   clk, reset : clock, synchronous active-high reset.
//   bus        : ivn_packer_if.slave (s_vn, s_vn_valid in; out_data,
//                out_valid out; out_ready in).
//   overflow   : sticky, set when a completed word is dropped on a full FIFO.
//   drop_count : 16-bit saturating count of dropped words; present only when
//                the macro IVN_PACKER_STATS_EN is defined.
module ivn_packer
    import ivn_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    ivn_packer_if.slave   bus,
    output logic          overflow
`ifdef IVN_PACKER_STATS_EN
   ,output logic [15:0]   drop_count
`endif
);

    localparam int ACC_W  = WORD_W + IVN_LANES;
    localparam int FILL_W = $clog2(WORD_W + IVN_LANES + 1);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              overflow_q, overflow_d;

    ivn_lvl_t          comp;
    logic [2:0]        idx;
    logic [2:0]        n;
    logic [FILL_W-1:0] total;
    logic [ACC_W-1:0]  merged;
    logic              word_done;
    logic [WORD_W-1:0] word;
    logic              fifo_full, fifo_empty;
    logic              pop, drop;

    always_comb begin
        // Compaction: valid bits packed towards bit 0 in ascending level order.
        comp = '0;
        idx  = '0;
        for (int i = 0; i < IVN_LANES; i++) begin
            if (bus.s_vn_valid[i]) begin
                comp[idx] = bus.s_vn[i];
                idx       = idx + 3'd1;
            end
        end
        n = ivn_popcount(bus.s_vn_valid);

        // Bits of acc at and above fill are always zero, so OR-ing in place
        // appends the new bits.
        total     = fill_q + FILL_W'(n);
        merged    = acc_q | (ACC_W'(comp) << fill_q);
        word_done = (total >= FILL_W'(WORD_W));
        word      = merged[WORD_W-1:0];

        acc_d  = merged;
        fill_d = total;
        if (word_done) begin
            acc_d  = merged >> WORD_W;
            fill_d = total - FILL_W'(WORD_W);
        end

        pop        = bus.out_ready & ~fifo_empty;
        drop       = word_done & fifo_full & ~pop;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    ivn_packer_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (word_done),
        .wr_data  (word),
        .rd_en    (bus.out_ready),
        .rd_data  (bus.out_data),
        .rd_valid (bus.out_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef IVN_PACKER_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ivn_packer.sv
// tb_ivn_packer: directed bench for ivn_packer with WORD_W=8, DEPTH=4.
// Inputs are driven after the falling edge, outputs sampled at the falling
// edge following each rising edge.
module tb_ivn_packer;

    logic clk;
    logic reset;
    logic overflow;
`ifdef IVN_PACKER_STATS_EN
    logic [15:0] drop_count;
`endif

    int n_checks;
    int n_errors;
    logic [7:0] exp_q[$];

    ivn_packer_if #(.WORD_W(8)) bus ();

    ivn_packer #(
        .WORD_W (8),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .overflow   (overflow)
`ifdef IVN_PACKER_STATS_EN
       ,.drop_count (drop_count)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, take the rising edge, return at the falling edge.
    task automatic tick(input logic [5:0] vld, input logic [5:0] vn, input logic rdy);
        bus.s_vn_valid = vld;
        bus.s_vn       = vn;
        bus.out_ready  = rdy;
        @(posedge clk);
        @(negedge clk);
        bus.s_vn_valid = '0;
        bus.s_vn       = '0;
        bus.out_ready  = 1'b0;
    endtask

    // Eight lane-0 bits, LSB first; rdy_last drives out_ready on the last bit.
    task automatic feed_word(input logic [7:0] w, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            tick(6'b000001, {5'b0, w[i]}, (i == 7) ? rdy_last : 1'b0);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bus.s_vn       = '0;
        bus.s_vn_valid = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef IVN_PACKER_STATS_EN
        chk("rst_drops", 32'(drop_count), 32'd0);
`endif
        reset = 1'b0;

        // Single lane: 1,0,1,1,0,0,1,0 -> 8'h4D
        tick(6'b000001, 6'd1, 1'b0);
        tick(6'b000001, 6'd0, 1'b0);
        tick(6'b000001, 6'd1, 1'b0);
        tick(6'b000001, 6'd1, 1'b0);
        tick(6'b000001, 6'd0, 1'b0);
        tick(6'b000001, 6'd0, 1'b0);
        tick(6'b000001, 6'd1, 1'b0);
        chk("t1_valid_7", 32'(bus.out_valid), 32'd0);
        tick(6'b000001, 6'd0, 1'b0);
        chk("t1_valid_8", 32'(bus.out_valid), 32'd1);
        chk("t1_data", 32'(bus.out_data), 32'h4D);
        tick(6'b000000, 6'd0, 1'b1);
        chk("t1_pop_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_hold_data", 32'(bus.out_data), 32'h4D);

        // Full lanes: 6 ones then 6 zeros -> 8'h3F, fill 4; then two 8'h00
        tick(6'b111111, 6'b111111, 1'b0);
        chk("t2_valid_a", 32'(bus.out_valid), 32'd0);
        tick(6'b111111, 6'b000000, 1'b0);
        chk("t2_valid_b", 32'(bus.out_valid), 32'd1);
        chk("t2_data_3f", 32'(bus.out_data), 32'h3F);
        tick(6'b111111, 6'b000000, 1'b1);
        chk("t2_pp1_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_pp1_data", 32'(bus.out_data), 32'h00);
        tick(6'b111111, 6'b000000, 1'b1);
        chk("t2_pp2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_pp2_data", 32'(bus.out_data), 32'h00);
        tick(6'b000000, 6'd0, 1'b1);
        chk("t2_empty", 32'(bus.out_valid), 32'd0);

        // Sparse valid: lanes 1,3,5 give bits 1,0,1 each cycle.
        // Nine bits 1,0,1,1,0,1,1,0,1 -> word 8'h6D, one bit (1) left over.
        tick(6'b101010, 6'b100010, 1'b0);
        tick(6'b101010, 6'b100010, 1'b0);
        chk("t3_valid_2", 32'(bus.out_valid), 32'd0);
        tick(6'b101010, 6'b100010, 1'b0);
        chk("t3_valid_3", 32'(bus.out_valid), 32'd1);
        chk("t3_data", 32'(bus.out_data), 32'h6D);
        // Leftover 1 followed by seven zeros -> 8'h01
        tick(6'b111111, 6'b000000, 1'b1);
        chk("t3_pop_valid", 32'(bus.out_valid), 32'd0);
        tick(6'b000001, 6'b000000, 1'b0);
        chk("t3_rem_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_rem_data", 32'(bus.out_data), 32'h01);
        tick(6'b000000, 6'd0, 1'b1);
        chk("t3_empty", 32'(bus.out_valid), 32'd0);

        // Fill FIFO to 4, then push/pop on a full FIFO, then drop one word.
        feed_word(8'h11, 1'b0);
        feed_word(8'h22, 1'b0);
        feed_word(8'h33, 1'b0);
        feed_word(8'h44, 1'b0);
        chk("t5_full_ovf", 32'(overflow), 32'd0);
        chk("t5_full_head", 32'(bus.out_data), 32'h11);
        feed_word(8'h55, 1'b1);
        chk("t5_pp_ovf", 32'(overflow), 32'd0);
        chk("t5_pp_head", 32'(bus.out_data), 32'h22);
        feed_word(8'h66, 1'b0);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_head", 32'(bus.out_data), 32'h22);
`ifdef IVN_PACKER_STATS_EN
        chk("t4_drops", 32'(drop_count), 32'd1);
`endif
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("t4_drain_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_drain_data", 32'(bus.out_data), 32'(e));
            tick(6'b000000, 6'd0, 1'b1);
        end
        chk("t4_drained", 32'(bus.out_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-word: five zero bits held, reset with live inputs, then
        // eight ones must form exactly 8'hFF.
        for (int i = 0; i < 5; i++) begin
            tick(6'b000001, 6'd0, 1'b0);
        end
        reset = 1'b1;
        tick(6'b111111, 6'b111111, 1'b1);
        reset = 1'b0;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_data", 32'(bus.out_data), 32'h00);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
`ifdef IVN_PACKER_STATS_EN
        chk("t6_rst_drops", 32'(drop_count), 32'd0);
`endif
        for (int i = 0; i < 7; i++) begin
            tick(6'b000001, 6'd1, 1'b0);
        end
        chk("t6_valid_7", 32'(bus.out_valid), 32'd0);
        tick(6'b000001, 6'd1, 1'b0);
        chk("t6_valid_8", 32'(bus.out_valid), 32'd1);
        chk("t6_data", 32'(bus.out_data), 32'hFF);
        tick(6'b000000, 6'd0, 1'b1);
        chk("t6_single", 32'(bus.out_valid), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
